// File: rtl/operand_forward_ctrl.sv
// operand_forward_ctrl
// Forwarding-select sequencer for the EX-stage operand A/B 5:1 muxes of a
// 4-stage ID/EX/MEM/WB pipeline. Tracks destination info for the instructions
// in EX, MEM and WB. Registers the mux selects so they line up with the
// instruction sitting in EX. Detects load-use hazards and inserts one bubble.
//
// Optional feature: define FWD_PERF_CNT_EN to add the STALL_CNT and FWD_CNT
// performance counters and their output ports.

module operand_forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ID_VALID,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic              ID_USE_RS1,
    input  logic              ID_USE_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_REG_WRITE,
    input  logic              ID_MEM_READ,
    input  logic              FLUSH,
    input  logic              PIPE_HOLD,
    output logic [SEL_W-1:0]  SEL_A,
    output logic [SEL_W-1:0]  SEL_B,
`ifdef FWD_PERF_CNT_EN
    output logic [31:0]       STALL_CNT,
    output logic [31:0]       FWD_CNT,
`endif
    output logic              STALL
);

    // Mux select encoding shared by both operand muxes.
    localparam logic [SEL_W-1:0] SEL_RF      = SEL_W'(0); // register-file data
    localparam logic [SEL_W-1:0] SEL_MEM_ALU = SEL_W'(1); // MEM-stage ALU result
    localparam logic [SEL_W-1:0] SEL_WB_ALU  = SEL_W'(2); // WB-stage ALU result
    localparam logic [SEL_W-1:0] SEL_WB_LOAD = SEL_W'(3); // WB-stage load data
    localparam logic [SEL_W-1:0] SEL_RETIRED = SEL_W'(4); // retired write-back register

    // Destination info for one in-flight instruction.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } stage_t;

    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;

    stage_t           id_rec;
    logic             enter_ex;
    logic [SEL_W-1:0] sel_a_calc;
    logic [SEL_W-1:0] sel_b_calc;
    logic [SEL_W-1:0] sel_a_nxt;
    logic [SEL_W-1:0] sel_b_nxt;

    // A stage can supply 'src' only if it really writes a non-x0 register.
    function automatic logic produces(input stage_t s, input logic [REG_AW-1:0] src);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == src);
    endfunction

    // Youngest producer wins: EX (moving to MEM), then MEM (moving to WB), then WB.
    function automatic logic [SEL_W-1:0] pick_sel(
        input logic              id_valid,
        input logic              use_src,
        input logic [REG_AW-1:0] src,
        input stage_t            ex,
        input stage_t            mem,
        input stage_t            wb
    );
        if (!id_valid || !use_src)  return SEL_RF;
        if (produces(ex, src))      return SEL_MEM_ALU;
        if (produces(mem, src))     return mem.mem_read ? SEL_WB_LOAD : SEL_WB_ALU;
        if (produces(wb, src))      return SEL_RETIRED;
        return SEL_RF;
    endfunction

    // Hazard detection and next-state selects for the instruction entering EX.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        STALL      = 1'b0;
        sel_a_calc = pick_sel(ID_VALID, ID_USE_RS1, ID_RS1, ex_q, mem_q, wb_q);
        sel_b_calc = pick_sel(ID_VALID, ID_USE_RS2, ID_RS2, ex_q, mem_q, wb_q);

        if (ID_VALID && !FLUSH && ex_q.valid && ex_q.reg_write && ex_q.mem_read &&
            (ex_q.rd != '0) &&
            ((ID_USE_RS1 && (ID_RS1 == ex_q.rd)) || (ID_USE_RS2 && (ID_RS2 == ex_q.rd))))
            STALL = 1'b1;

        enter_ex = !(FLUSH || STALL);

        id_rec.valid     = ID_VALID;
        id_rec.rd        = ID_RD;
        id_rec.reg_write = ID_REG_WRITE;
        id_rec.mem_read  = ID_MEM_READ;

        sel_a_nxt = enter_ex ? sel_a_calc : SEL_RF;
        sel_b_nxt = enter_ex ? sel_b_calc : SEL_RF;
    end

    // Stage-record shift and select registers; reset empties the pipeline.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments let wb/mem/ex all sample the pre-edge values.
        if (RESET) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            SEL_A <= SEL_RF;
            SEL_B <= SEL_RF;
        end else if (!PIPE_HOLD) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= enter_ex ? id_rec : '0;
            SEL_A <= sel_a_nxt;
            SEL_B <= sel_b_nxt;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] fwd_inc;

    // Number of non-register-file selects latched on this edge (0, 1 or 2).
    always_comb begin
        fwd_inc = 32'(sel_a_nxt != SEL_RF) + 32'(sel_b_nxt != SEL_RF);
    end

    // Free-running counters that wrap at 2^32 and freeze with the pipeline.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            STALL_CNT <= '0;
            FWD_CNT   <= '0;
        end else if (!PIPE_HOLD) begin
            if (STALL)
                STALL_CNT <= STALL_CNT + 32'd1;
            FWD_CNT <= FWD_CNT + fwd_inc;
        end
    end
`endif

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed bench for operand_forward_ctrl with hand-computed expectations.
// Counter checks are compiled in only when FWD_PERF_CNT_EN is defined.

module tb_operand_forward_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ID_VALID;
    logic [4:0] ID_RS1;
    logic [4:0] ID_RS2;
    logic       ID_USE_RS1;
    logic       ID_USE_RS2;
    logic [4:0] ID_RD;
    logic       ID_REG_WRITE;
    logic       ID_MEM_READ;
    logic       FLUSH;
    logic       PIPE_HOLD;
    logic [2:0] SEL_A;
    logic [2:0] SEL_B;
    logic       STALL;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] STALL_CNT;
    logic [31:0] FWD_CNT;
`endif

    int n_total = 0;
    int n_bad   = 0;

    operand_forward_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ID_VALID     (ID_VALID),
        .ID_RS1       (ID_RS1),
        .ID_RS2       (ID_RS2),
        .ID_USE_RS1   (ID_USE_RS1),
        .ID_USE_RS2   (ID_USE_RS2),
        .ID_RD        (ID_RD),
        .ID_REG_WRITE (ID_REG_WRITE),
        .ID_MEM_READ  (ID_MEM_READ),
        .FLUSH        (FLUSH),
        .PIPE_HOLD    (PIPE_HOLD),
        .SEL_A        (SEL_A),
        .SEL_B        (SEL_B),
`ifdef FWD_PERF_CNT_EN
        .STALL_CNT    (STALL_CNT),
        .FWD_CNT      (FWD_CNT),
`endif
        .STALL        (STALL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input int v, input int rs1, input int rs2, input int u1,
                          input int u2, input int rd, input int rw, input int mr);
        ID_VALID     = 1'(v);
        ID_RS1       = 5'(rs1);
        ID_RS2       = 5'(rs2);
        ID_USE_RS1   = 1'(u1);
        ID_USE_RS2   = 1'(u2);
        ID_RD        = 5'(rd);
        ID_REG_WRITE = 1'(rw);
        ID_MEM_READ  = 1'(mr);
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        nop();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        #1;
    endtask

    task automatic check_sel(input string tag, input int a, input int b);
        check({tag, "_sel_a"}, 32'(SEL_A), a);
        check({tag, "_sel_b"}, 32'(SEL_B), b);
    endtask

    initial begin
        RESET     = 1'b0;
        FLUSH     = 1'b0;
        PIPE_HOLD = 1'b0;
        nop();
        @(negedge CLK);
        do_reset();
        check_sel("reset", 0, 0);
        check("reset_stall", 32'(STALL), 0);

        // add x5,x1,x2 ; sub x6,x5,x7 back to back -> EX forward of rs1.
        set_id(1, 1, 2, 1, 1, 5, 1, 0);
        check("add_stall", 32'(STALL), 0);
        step();
        check_sel("add_in_ex", 0, 0);
        set_id(1, 5, 7, 1, 1, 6, 1, 0);
        check("sub_stall", 32'(STALL), 0);
        step();
        check_sel("sub_fwd", 1, 0);

        // lw x5 ; add x6,x5,x5 -> one stall, bubble, then WB load data.
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 5, 5, 1, 1, 6, 1, 0);
        check("lu_stall_on", 32'(STALL), 1);
        step();
        check_sel("lu_bubble", 0, 0);
        check("lu_stall_off", 32'(STALL), 0);
        step();
        check_sel("lu_fwd", 3, 3);
`ifdef FWD_PERF_CNT_EN
        check("lu_stall_cnt", int'(STALL_CNT), 1);
        check("lu_fwd_cnt", int'(FWD_CNT), 2);
`endif

        // add x5 ; nop ; nop ; use x5 -> retired write-back register.
        do_reset();
        set_id(1, 1, 2, 1, 1, 5, 1, 0);
        step();
        nop();
        step();
        check_sel("nop_in_ex", 0, 0);
        step();
        set_id(1, 5, 0, 1, 0, 7, 1, 0);
        step();
        check_sel("wb_fwd", 4, 0);

        // x5 written by two producers -> youngest (EX) wins.
        do_reset();
        set_id(1, 1, 2, 1, 1, 5, 1, 0);
        step();
        set_id(1, 3, 4, 1, 1, 5, 1, 0);
        step();
        set_id(1, 5, 5, 1, 1, 8, 1, 0);
        step();
        check_sel("youngest", 1, 1);

        // lw x0 ; add using x0 -> no stall, no forward.
        do_reset();
        set_id(1, 1, 0, 1, 0, 0, 1, 1);
        step();
        set_id(1, 0, 0, 1, 1, 6, 1, 0);
        check("x0_stall", 32'(STALL), 0);
        step();
        check_sel("x0_sel", 0, 0);

        // lw x5 ; consumer with rs1=x5 but ID_USE_RS1=0 -> no stall.
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 5, 3, 0, 1, 6, 1, 0);
        check("nouse_stall", 32'(STALL), 0);
        step();
        check_sel("nouse_sel", 0, 0);

        // FLUSH with a load-use condition -> no stall, bubble in EX.
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 5, 5, 1, 1, 6, 1, 0);
        FLUSH = 1'b1;
        #1;
        check("flush_stall", 32'(STALL), 0);
        step();
        FLUSH = 1'b0;
        #1;
        check_sel("flush_bubble", 0, 0);
        check("post_flush_stall", 32'(STALL), 0);
        step();
        check_sel("post_flush_fwd", 3, 3);

        // PIPE_HOLD for 3 cycles: selects and records frozen, then resume.
        do_reset();
        set_id(1, 1, 2, 1, 1, 5, 1, 0);
        step();
        set_id(1, 5, 7, 1, 1, 6, 1, 0);
        step();
        check_sel("pre_hold", 1, 0);
        set_id(1, 6, 5, 1, 1, 9, 1, 0);
        PIPE_HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_sel($sformatf("hold%0d", i), 1, 0);
        end
        PIPE_HOLD = 1'b0;
        step();
        check_sel("resume", 1, 2);

        // RESET during a stall cycle -> pipeline restarts empty.
        do_reset();
        set_id(1, 1, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 5, 5, 1, 1, 6, 1, 0);
        check("rst_mid_stall_on", 32'(STALL), 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        #1;
        check("rst_mid_stall_off", 32'(STALL), 0);
        check_sel("rst_mid_sel", 0, 0);
        step();
        check_sel("rst_mid_enter", 0, 0);
`ifdef FWD_PERF_CNT_EN
        check("rst_stall_cnt", int'(STALL_CNT), 0);
        check("rst_fwd_cnt", int'(FWD_CNT), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
